// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [LEN_W-1:0]  len_t;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output s_valid, s_data,
        input  s_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Assembles four accepted bytes into one little-endian word; byte0 lands in bits [7:0].
module imem_word_packer
    import imem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       byte_en,
    input  logic [7:0] byte_data,
    output logic       word_vld,
    output word_t      word
);
    logic [1:0]  byte_cnt;
    logic [23:0] asm_q;

    // Shift right so the oldest byte ends up in the low lane.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            byte_cnt <= '0;
            asm_q    <= '0;
        end else if (byte_en) begin
            byte_cnt <= byte_cnt + 2'd1;
            asm_q    <= {byte_data, asm_q[23:8]};
        end
    end

    assign word_vld = byte_en && (byte_cnt == 2'(BYTES_PER_WORD - 1));
    assign word     = {byte_data, asm_q};
endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte image into instruction memory and releases the core when done.
// Build option IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
//
// state  | meaning
// LEN_LO | waiting for word count low byte
// LEN_HI | waiting for word count high byte, range check
// DATA   | receiving data bytes, one memory write per 4 bytes
// CHK    | waiting for checksum byte (checksum build only)
// DONE   | image written, core released
// ERR    | bad length or checksum, core held
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          core_run,
    output logic          load_done,
    output logic          err
);
    import imem_pkg::*;

    state_t            state, next;
    logic              ready;
    logic              hs, byte_en, clr, restart, last_word, len_bad;
    logic [7:0]        len_lo;
    len_t              len, len_full, word_cnt;
    logic              word_vld;
    word_t             word;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    assign hs        = bus.s_valid && ready;
    assign byte_en   = hs && (state == DATA);
    assign restart   = start && ((state == DONE) || (state == ERR));
    assign clr       = restart || (hs && (state == LEN_HI));
    assign len_full  = {bus.s_data, len_lo};
    assign len_bad   = (len_full == '0) || (len_full > LEN_W'(DEPTH));
    assign last_word = word_vld && (word_cnt == len - LEN_W'(1));

    imem_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .byte_en   (byte_en),
        .byte_data (bus.s_data),
        .word_vld  (word_vld),
        .word      (word)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] chk_acc;

    always_ff @(posedge clk) begin
        if (rst || clr)   chk_acc <= '0;
        else if (byte_en) chk_acc <= chk_acc ^ bus.s_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= LEN_LO;
        else     state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            LEN_LO: if (hs) next = LEN_HI;
            LEN_HI: if (hs) next = len_bad ? ERR : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            DATA:   if (last_word) next = CHK;
            CHK:    if (hs) next = (bus.s_data == chk_acc) ? DONE : ERR;
`else
            DATA:   if (last_word) next = DONE;
            CHK:    next = ERR;
`endif
            DONE, ERR: if (start) next = LEN_LO;
            default: next = LEN_LO;
        endcase
    end

    // Release is held off while the final write is still on the bus.
    always_comb begin
        ready     = 1'b0;
        core_run  = 1'b0;
        load_done = 1'b0;
        err       = 1'b0;
        case (state)
            LEN_LO, LEN_HI, DATA, CHK: ready = 1'b1;
            DONE: begin
                core_run  = !mem_we_q;
                load_done = !mem_we_q;
            end
            ERR:  err = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            word_cnt    <= '0;
            len_lo      <= '0;
            len         <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if (hs && (state == LEN_LO)) len_lo <= bus.s_data;
            if (restart) begin
                word_cnt   <= '0;
                mem_addr_q <= '0;
            end else if (hs && (state == LEN_HI)) begin
                len      <= len_full;
                word_cnt <= '0;
            end else if (word_vld) begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= word_cnt[ADDR_W-1:0];
                mem_wdata_q <= DATA_W'(word);
                word_cnt    <= word_cnt + LEN_W'(1);
            end
        end
    end

    assign bus.s_ready   = ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
